// File: rtl/if_pc_ifid_stage.sv
// Fetch-stage program counter and IF/ID pipeline register with stall/flush control.
// Optional alignment flag on captured instructions: define IF_ALIGN_CHECK_EN.
module if_pc_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        id_misaligned
);

    logic pc_load;
    logic id_capture;

    // A flush is a redirect, so it updates pc even while the hazard unit stalls.
    assign pc_load    = flush || !stall;
    assign id_capture = !flush && !stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
        end else if (flush) begin
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
            id_instr    <= NOP_INSTR;
            id_valid    <= 1'b0;
        end else if (id_capture) begin
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
            id_instr    <= imem_rdata;
            id_valid    <= 1'b1;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_misaligned <= 1'b0;
        end else if (flush) begin
            id_misaligned <= 1'b0;
        end else if (id_capture) begin
            id_misaligned <= (pc[1:0] != 2'b00);
        end
    end
`else
    assign id_misaligned = 1'b0;
`endif

endmodule
